// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. One operand set {a, b, cin} is accepted over a
//   valid/ready handshake. The operands are then added LSB-first, one bit per
//   clock, through a single full-adder slice and a registered carry. The result
//   {carry, sum} is returned over a valid/ready output handshake.
//
//   Sequence of states: IDLE (accept) -> RUN (WIDTH cycles) -> DONE (hold
//   result until out_ready) -> IDLE.
//
// Parameters
//   WIDTH      operand/sum width in bits, >= 1
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   a, b, cin valid this cycle
//   in_ready   block can accept an operand set (IDLE and not in reset)
//   a, b       operands, sampled only at the accepting edge
//   cin        carry-in, sampled only at the accepting edge
//   out_valid  sum/carry valid (DONE state)
//   out_ready  consumer accepts the result
//   sum        (a+b+cin) mod 2^WIDTH, registered
//   carry      carry-out of the MSB, registered
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-adder slice helpers.
  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | ((x ^ y) & ci);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             bit_s;
  logic [WIDTH:0]   shift_s;

  // Next-state and datapath computation for the serial add.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    bit_s   = fa_sum(a_q[0], b_q[0], c_q);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
    // Built from a WIDTH+1 vector so WIDTH=1 needs no empty slice.
    shift_s = {bit_s, s_q};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          s_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        c_d   = fa_carry(a_q[0], b_q[0], c_q);
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        s_d   = shift_s[WIDTH:1];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags are decoded from state; in_ready is also masked in reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = s_q;
  assign carry     = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder. Three instances (WIDTH=8, 4, 1) share
//   one clock. Expected {carry, sum} values are pushed to a per-instance queue
//   when an operand set is accepted and popped by a monitor when the output
//   handshake completes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- WIDTH = 8 instance ----------------
  logic       rst8, in_valid8, in_ready8, cin8, out_valid8, out_ready8, carry8;
  logic [7:0] a8, b8, sum8;
  logic [8:0] q8[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry(carry8)
  );

  // ---------------- WIDTH = 4 instance ----------------
  logic       rst4, in_valid4, in_ready4, cin4, out_valid4, out_ready4, carry4;
  logic [3:0] a4, b4, sum4;
  logic [4:0] q4[$];
  int         recv4 = 0;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .carry(carry4)
  );

  // ---------------- WIDTH = 1 instance ----------------
  logic       rst1, in_valid1, in_ready1, cin1, out_valid1, out_ready1, carry1;
  logic [0:0] a1, b1, sum1;
  logic [1:0] q1[$];

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .carry(carry1)
  );

  // Single comparison point: counts and reports.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitors: compare on every completed output handshake.
  always @(negedge clk) begin
    if (!rst8 && out_valid8 && out_ready8) begin
      if (q8.size() == 0) check_eq("w8_unexpected_result", {23'd0, carry8, sum8}, 32'hFFFF_FFFF);
      else check_eq("w8_result", {23'd0, carry8, sum8}, {23'd0, q8.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst4 && out_valid4 && out_ready4) begin
      recv4++;
      if (q4.size() == 0) check_eq("w4_unexpected_result", {27'd0, carry4, sum4}, 32'hFFFF_FFFF);
      else check_eq("w4_result", {27'd0, carry4, sum4}, {27'd0, q4.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst1 && out_valid1 && out_ready1) begin
      if (q1.size() == 0) check_eq("w1_unexpected_result", {30'd0, carry1, sum1}, 32'hFFFF_FFFF);
      else check_eq("w1_result", {30'd0, carry1, sum1}, {30'd0, q1.pop_front()});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer an operand set to the WIDTH=8 instance; returns #1 after the accepting edge.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input bit push);
    int n;
    a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
    n = 0;
    while (!in_ready8 && n < 50) begin tick(); n++; end
    check_eq("w8_accept_timeout", n < 50, 1);
    if (push) q8.push_back(9'(av) + 9'(bv) + 9'(cv));
    tick();
    in_valid8 = 1'b0;
    // Operands are sampled only at the accepting edge; disturb them now.
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  // Cycles from the accepting edge until out_valid (bounded).
  task automatic wait_out8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 40) begin tick(); lat++; end
  endtask

  task automatic tick4;
    @(posedge clk);
    #1;
    out_ready4 = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int lat;
    int n;
    logic [8:0] exp9;

    rst8 = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
    in_valid8 = 1'b0; in_valid4 = 1'b0; in_valid1 = 1'b0;
    out_ready8 = 1'b1; out_ready4 = 1'b0; out_ready1 = 1'b1;
    a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
    a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (2) tick();

    // Reset state
    check_eq("rst_in_ready", in_ready8, 0);
    check_eq("rst_out_valid", out_valid8, 0);
    check_eq("rst_sum", sum8, 0);
    check_eq("rst_carry", carry8, 0);
    rst8 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
    tick();
    check_eq("idle_in_ready", in_ready8, 1);

    // Basic add with latency
    op8(8'h5A, 8'h33, 1'b0, 1'b1);
    check_eq("run_in_ready", in_ready8, 0);
    wait_out8(lat);
    check_eq("lat_5a_33", lat, 8);
    check_eq("sum_5a_33", sum8, 8'h8D);
    check_eq("carry_5a_33", carry8, 0);
    tick();
    check_eq("ready_after_done", in_ready8, 1);
    check_eq("valid_drops", out_valid8, 0);

    // Overflow cases
    op8(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_out8(lat);
    check_eq("sum_ff_01", sum8, 8'h00);
    check_eq("carry_ff_01", carry8, 1);
    tick();
    op8(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_out8(lat);
    check_eq("lat_ff_ff", lat, 8);
    check_eq("sum_ff_ff", sum8, 8'hFF);
    check_eq("carry_ff_ff", carry8, 1);
    tick();

    // Backpressure in DONE while in_valid is pulsed with new operands
    out_ready8 = 1'b0;
    op8(8'h12, 8'h34, 1'b1, 1'b1);
    wait_out8(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = ~in_valid8;
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
      check_eq("bp_out_valid", out_valid8, 1);
      check_eq("bp_sum", sum8, 8'h47);
      check_eq("bp_carry", carry8, 0);
      check_eq("bp_in_ready", in_ready8, 0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    check_eq("bp_released", out_valid8, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid8) n++;
    end
    check_eq("bp_no_extra_op", n, 0);
    check_eq("bp_queue_empty", q8.size(), 0);

    // Reset mid-RUN at bit 3: partial result discarded
    op8(8'hA5, 8'h0F, 1'b0, 1'b0);
    repeat (3) tick();
    rst8 = 1'b1;
    tick();
    check_eq("mid_rst_in_ready", in_ready8, 0);
    check_eq("mid_rst_out_valid", out_valid8, 0);
    check_eq("mid_rst_sum", sum8, 0);
    check_eq("mid_rst_carry", carry8, 0);
    rst8 = 1'b0;
    #1;
    check_eq("post_rst_in_ready", in_ready8, 1);
    op8(8'hA5, 8'h0F, 1'b0, 1'b1);
    wait_out8(lat);
    check_eq("post_rst_lat", lat, 8);
    tick();

    // A few random operand sets through the scoreboard
    for (int i = 0; i < 6; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      wait_out8(lat);
      check_eq("rand_lat", lat, 8);
      tick();
    end
    check_eq("w8_queue_drained", q8.size(), 0);

    // WIDTH=4: exhaustive a/b/cin with random gaps and backpressure
    for (int i = 0; i < 512; i++) begin
      exp9 = 9'(i);
      repeat ($urandom_range(0, 2)) tick4();
      a4 = exp9[3:0]; b4 = exp9[7:4]; cin4 = exp9[8];
      in_valid4 = 1'b1;
      n = 0;
      while (!in_ready4 && n < 200) begin tick4(); n++; end
      if (n >= 200) check_eq("w4_accept_timeout", n, 0);
      q4.push_back(5'(exp9[3:0]) + 5'(exp9[7:4]) + 5'(exp9[8]));
      tick4();
      in_valid4 = 1'b0;
    end
    n = 0;
    while (recv4 < 512 && n < 500) begin tick4(); n++; end
    check_eq("w4_received", recv4, 512);
    check_eq("w4_queue_empty", q4.size(), 0);

    // WIDTH=1
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
    #1;
    check_eq("w1_in_ready", in_ready1, 1);
    q1.push_back(2'b11);
    tick();
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    tick();
    check_eq("w1_lat1_valid", out_valid1, 1);
    check_eq("w1_sum", sum1, 1);
    check_eq("w1_carry", carry1, 1);
    tick();
    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; in_valid1 = 1'b1;
    q1.push_back(2'b01);
    tick();
    in_valid1 = 1'b0;
    tick();
    check_eq("w1_b_valid", out_valid1, 1);
    tick();
    check_eq("w1_queue_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
